// File: rtl/dif_serial_arbiter.sv
// dif_serial_arbiter
// Round-robin arbiter and MSB-first serializer. It shares one serial data
// lane among N_REQ parallel-word requesters. A winner's word is captured at
// grant time and shifted out under a frame qualifier, followed by one idle
// gap cycle before the next arbitration decision.
module dif_serial_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data,
    input  logic                   pause,
    output logic [N_REQ-1:0]       gnt,
    output logic                   d,
    output logic                   frame,
    output logic                   busy,
    output logic [IDX_W-1:0]       owner
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] ptr_next;
    logic             any_req;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bitcnt;
    logic [WIDTH-1:0] words [N_REQ];

    assign any_req = |req;

    // Split the flat data bus into one word per requester.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            words[i] = data[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search: scan from ptr upward with wrap, first set bit wins.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Pointer for the next search is one past the winner, wrapping at N_REQ.
    always_comb begin
        ptr_next = winner + IDX_W'(1);
        if (winner == IDX_W'(N_REQ - 1)) begin
            ptr_next = '0;
        end
    end

    // State register; reset returns to IDLE and aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; pause only matters while shifting.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (!pause && bitcnt == '0) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture on grant, shift while not paused; gnt is a single pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr    <= '0;
            owner  <= '0;
            shreg  <= '0;
            bitcnt <= '0;
            gnt    <= '0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        shreg  <= words[winner];
                        owner  <= winner;
                        ptr    <= ptr_next;
                        gnt    <= N_REQ'(1) << winner;
                        bitcnt <= CNT_W'(WIDTH - 1);
                    end
                end
                SHIFT: begin
                    if (!pause) begin
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                        if (bitcnt != '0) begin
                            bitcnt <= bitcnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Serial outputs decoded purely from registered state and shift register.
    always_comb begin
        d     = 1'b0;
        frame = 1'b0;
        busy  = (state != IDLE);
        if (state == SHIFT) begin
            d     = shreg[WIDTH-1];
            frame = 1'b1;
        end
    end

endmodule

// File: tb/tb_dif_serial_arbiter.sv
// tb_dif_serial_arbiter
// Scenario tasks drive the arbiter and compare its serial output against a
// transaction-level model: round-robin winner from a pointer, and the expected
// bit stream built from the captured word with paused bits repeated.
module tb_dif_serial_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic           pause;
    logic [N-1:0]   gnt;
    logic           d;
    logic           frame;
    logic           busy;
    logic [1:0]     owner;

    int total   = 0;
    int bad     = 0;
    int cyc     = 0;
    int m_ptr   = 0;
    int m_owner = 0;

    dif_serial_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .data  (data),
        .pause (pause),
        .gnt   (gnt),
        .d     (d),
        .frame (frame),
        .busy  (busy),
        .owner (owner)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the bench itself stalls.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Round-robin model: first requester at or after p, wrapping.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (p + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    // Expected serial stream: MSB first, bit at position pa repeated pl extra times.
    function automatic void exp_frame(input logic [W-1:0] w, input int pa, input int pl,
                                      output logic [63:0] es, output int el);
        int reps;
        es = '0;
        el = 0;
        for (int j = W - 1; j >= 0; j--) begin
            reps = ((W - 1 - j) == pa) ? pl + 1 : 1;
            for (int r = 0; r < reps; r++) begin
                es = {es[62:0], w[j]};
                el++;
            end
        end
    endfunction

    function automatic logic [W-1:0] word_of(input int i);
        return data[i*W +: W];
    endfunction

    // Synchronous reset with noisy inputs, then one quiet IDLE cycle.
    task automatic applyStimulus_reset();
        rst_n = 1'b0;
        req   = N'($urandom);
        pause = 1'($urandom);
        step();
        step();
        rst_n = 1'b1;
        req   = '0;
        pause = 1'b0;
        step();
        m_ptr   = 0;
        m_owner = 0;
    endtask

    // Issue one request pattern and record what the DUT does through to IDLE.
    task automatic run_frame(input logic [N-1:0] reqv, input logic [N-1:0] late,
                             input int pause_at, input int pause_len, input logic idle_pause,
                             output logic [N-1:0] g_first, output int g_cnt, output int g_cyc,
                             output int own, output logic [63:0] ds, output int flen,
                             output logic gap_ok, output logic idle_ok, output logic tmo);
        int c;
        req   = reqv;
        pause = idle_pause;
        g_cnt = 0;
        g_cyc = -1;
        ds    = '0;
        flen  = 0;
        tmo   = 1'b0;
        c     = 0;
        step();
        g_first = gnt;
        own     = int'(owner);
        while (frame === 1'b1 && !tmo) begin
            if (gnt !== '0) begin
                g_cnt++;
                if (g_cyc < 0) g_cyc = cyc;
            end
            ds    = {ds[62:0], d};
            flen++;
            req   = req & ~gnt;
            if (c >= 2) req = req | late;
            pause = (c >= pause_at && c < pause_at + pause_len);
            c++;
            if (c > 60) tmo = 1'b1;
            step();
        end
        pause = idle_pause;
        if (gnt !== '0) g_cnt++;
        if (flen > 0) gap_ok = (d === 1'b0 && frame === 1'b0 && busy === 1'b1);
        else          gap_ok = (d === 1'b0 && frame === 1'b0 && busy === 1'b0);
        step();
        idle_ok = (busy === 1'b0 && frame === 1'b0 && gnt === '0 && d === 1'b0);
        pause = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        pause = 1'b1;
        step();
        step();
        total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL reset_gnt: got %b want 0000", gnt); end
        total++; if (d !== 1'b0)      begin bad++; $display("[TB] FAIL reset_d: got %b want 0", d); end
        total++; if (frame !== 1'b0)  begin bad++; $display("[TB] FAIL reset_frame: got %b want 0", frame); end
        total++; if (busy !== 1'b0)   begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        total++; if (owner !== 2'd0)  begin bad++; $display("[TB] FAIL reset_owner: got %0d want 0", owner); end
        rst_n = 1'b1;
        req   = '0;
        pause = 1'b0;
        step();
        total++; if (busy !== 1'b0)   begin bad++; $display("[TB] FAIL reset_idle_busy: got %b want 0", busy); end
        m_ptr   = 0;
        m_owner = 0;
    endtask

    task automatic test_single();
        logic [N-1:0] gf;
        int gc, gcy, own, fl, el;
        logic [63:0] ds, es;
        logic gok, iok, tmo;
        data = {$urandom, 24'h0, 8'hA5};
        data[W +: W] = 8'h3C;
        run_frame(4'b0001, 4'b0000, 99, 0, 1'b0, gf, gc, gcy, own, ds, fl, gok, iok, tmo);
        exp_frame(8'hA5, 99, 0, es, el);
        total++; if (gf !== 4'b0001) begin bad++; $display("[TB] FAIL single_gnt: got %b want 0001", gf); end
        total++; if (gc != 1)        begin bad++; $display("[TB] FAIL single_gnt_len: got %0d want 1", gc); end
        total++; if (own != 0)       begin bad++; $display("[TB] FAIL single_owner: got %0d want 0", own); end
        total++; if (fl != el || ds !== es) begin bad++; $display("[TB] FAIL single_stream: got %h/%0d want %h/%0d", ds, fl, es, el); end
        total++; if (!gok)           begin bad++; $display("[TB] FAIL single_gap: got d=%b frame=%b want gap", d, frame); end
        total++; if (!iok || tmo)    begin bad++; $display("[TB] FAIL single_idle: got busy=%b tmo=%b want idle", busy, tmo); end
        m_ptr   = 1;
        m_owner = 0;
    endtask

    task automatic test_all_req();
        logic [N-1:0] rem, gf, eg;
        int gc, gcy, own, fl, el, ew, prev;
        logic [63:0] ds, es;
        logic gok, iok, tmo;
        applyStimulus_reset();
        for (int i = 0; i < N; i++) data[i*W +: W] = W'($urandom);
        rem  = 4'b1111;
        prev = -1;
        for (int k = 0; k < N; k++) begin
            ew = rr_pick(rem, m_ptr);
            eg = N'(1) << ew;
            run_frame(rem, 4'b0000, 99, 0, 1'b0, gf, gc, gcy, own, ds, fl, gok, iok, tmo);
            exp_frame(word_of(ew), 99, 0, es, el);
            total++; if (own != k || ew != k) begin bad++; $display("[TB] FAIL all_order: got %0d want %0d", own, k); end
            total++; if (gf !== eg)   begin bad++; $display("[TB] FAIL all_gnt: got %b want %b", gf, eg); end
            total++; if (ds !== es || fl != el) begin bad++; $display("[TB] FAIL all_stream: got %h want %h", ds, es); end
            if (prev >= 0) begin
                total++; if (gcy - prev != W + 2) begin bad++; $display("[TB] FAIL all_spacing: got %0d want %0d", gcy - prev, W + 2); end
            end
            prev    = gcy;
            rem     = rem & ~eg;
            m_ptr   = (ew + 1) % N;
            m_owner = ew;
        end
    endtask

    task automatic test_rr_wrap();
        logic [N-1:0] gf;
        int gc, gcy, own, fl;
        logic [63:0] ds;
        logic gok, iok, tmo;
        applyStimulus_reset();
        run_frame(4'b0100, 4'b0000, 99, 0, 1'b0, gf, gc, gcy, own, ds, fl, gok, iok, tmo);
        total++; if (own != 2) begin bad++; $display("[TB] FAIL wrap_first: got %0d want 2", own); end
        run_frame(4'b0011, 4'b0000, 99, 0, 1'b0, gf, gc, gcy, own, ds, fl, gok, iok, tmo);
        total++; if (own != 0 || gf !== 4'b0001) begin bad++; $display("[TB] FAIL wrap_second: got %0d/%b want 0/0001", own, gf); end
        run_frame(req, 4'b0000, 99, 0, 1'b0, gf, gc, gcy, own, ds, fl, gok, iok, tmo);
        total++; if (own != 1 || gf !== 4'b0010) begin bad++; $display("[TB] FAIL wrap_third: got %0d/%b want 1/0010", own, gf); end
        m_ptr   = 2;
        m_owner = 1;
    endtask

    task automatic test_pause();
        logic [N-1:0] gf;
        int gc, gcy, own, fl, el;
        logic [63:0] ds, es;
        logic gok, iok, tmo;
        data[0 +: W] = 8'hF0;
        run_frame(4'b0001, 4'b0000, 2, 3, 1'b1, gf, gc, gcy, own, ds, fl, gok, iok, tmo);
        exp_frame(8'hF0, 2, 3, es, el);
        total++; if (fl != 11)       begin bad++; $display("[TB] FAIL pause_len: got %0d want 11", fl); end
        total++; if (ds !== es)      begin bad++; $display("[TB] FAIL pause_stream: got %h want %h", ds, es); end
        total++; if (!gok || !iok)   begin bad++; $display("[TB] FAIL pause_tail: got gap=%b idle=%b want 1/1", gok, iok); end
        data[0 +: W] = W'($urandom);
        run_frame(4'b0001, 4'b0000, 0, 2, 1'b0, gf, gc, gcy, own, ds, fl, gok, iok, tmo);
        exp_frame(word_of(0), 0, 2, es, el);
        total++; if (gc != 1 || gf !== 4'b0001) begin bad++; $display("[TB] FAIL pause_first_gnt: got %0d/%b want 1/0001", gc, gf); end
        total++; if (ds !== es || fl != el) begin bad++; $display("[TB] FAIL pause_first_stream: got %h/%0d want %h/%0d", ds, fl, es, el); end
        m_ptr   = 1;
        m_owner = 0;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] gf;
        int gc, gcy, own, fl, el;
        logic [63:0] ds, es;
        logic gok, iok, tmo;
        data = {$urandom, $urandom};
        req  = 4'b0100;
        step();
        total++; if (gnt !== 4'b0100) begin bad++; $display("[TB] FAIL rstmid_gnt: got %b want 0100", gnt); end
        req = '0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++; if ({gnt, d, frame, busy} !== 7'd0 || owner !== 2'd0) begin
            bad++; $display("[TB] FAIL rstmid_outputs: got gnt=%b d=%b frame=%b busy=%b owner=%0d want all 0", gnt, d, frame, busy, owner);
        end
        m_ptr   = 0;
        m_owner = 0;
        run_frame(4'b1010, 4'b0000, 99, 0, 1'b0, gf, gc, gcy, own, ds, fl, gok, iok, tmo);
        total++; if (own != 1) begin bad++; $display("[TB] FAIL rstmid_ptr: got %0d want 1", own); end
        run_frame(4'b1000, 4'b0000, 99, 0, 1'b0, gf, gc, gcy, own, ds, fl, gok, iok, tmo);
        exp_frame(word_of(3), 99, 0, es, el);
        total++; if (own != 3 || ds !== es || fl != el) begin bad++; $display("[TB] FAIL rstmid_new: got %0d/%h want 3/%h", own, ds, es); end
        m_ptr   = 0;
        m_owner = 3;
    endtask

    task automatic test_late_req();
        logic [N-1:0] gf;
        int gc, gcy, gcy0, own, fl, el;
        logic [63:0] ds, es;
        logic gok, iok, tmo;
        data = {$urandom, $urandom};
        run_frame(4'b0001, 4'b0010, 99, 0, 1'b0, gf, gc, gcy0, own, ds, fl, gok, iok, tmo);
        exp_frame(word_of(0), 99, 0, es, el);
        total++; if (gc != 1 || ds !== es) begin bad++; $display("[TB] FAIL late_first: got %0d/%h want 1/%h", gc, ds, es); end
        total++; if (!iok) begin bad++; $display("[TB] FAIL late_idle: got busy=%b want 0", busy); end
        run_frame(req, 4'b0000, 99, 0, 1'b0, gf, gc, gcy, own, ds, fl, gok, iok, tmo);
        total++; if (gf !== 4'b0010 || gcy - gcy0 != W + 2) begin bad++; $display("[TB] FAIL late_grant: got %b at +%0d want 0010 at +%0d", gf, gcy - gcy0, W + 2); end
        m_ptr   = 2;
        m_owner = 1;
    endtask

    task automatic test_random();
        logic [N-1:0] rv, lt, gf, eg;
        int gc, gcy, own, fl, el, ew, pa, pl;
        logic [63:0] ds, es;
        logic gok, iok, tmo, ip;
        for (int it = 0; it < 30; it++) begin
            rv = N'($urandom_range(0, 15));
            lt = N'($urandom);
            for (int i = 0; i < N; i++) data[i*W +: W] = W'($urandom);
            pa = $urandom_range(0, W - 1);
            pl = $urandom_range(0, 3);
            ip = 1'($urandom);
            ew = rr_pick(rv, m_ptr);
            run_frame(rv, lt, pa, pl, ip, gf, gc, gcy, own, ds, fl, gok, iok, tmo);
            if (ew < 0) begin
                total++; if (gf !== '0 || fl != 0 || own != m_owner) begin bad++; $display("[TB] FAIL rand_noreq: got %b/%0d/%0d want 0/0/%0d", gf, fl, own, m_owner); end
            end else begin
                eg = N'(1) << ew;
                exp_frame(word_of(ew), pa, pl, es, el);
                total++; if (gf !== eg || own != ew || gc != 1) begin bad++; $display("[TB] FAIL rand_grant: got %b/%0d/%0d want %b/%0d/1", gf, own, gc, eg, ew); end
                total++; if (ds !== es || fl != el) begin bad++; $display("[TB] FAIL rand_stream: got %h/%0d want %h/%0d", ds, fl, es, el); end
                m_ptr   = (ew + 1) % N;
                m_owner = ew;
            end
            total++; if (!gok || !iok || tmo) begin bad++; $display("[TB] FAIL rand_tail: got gap=%b idle=%b tmo=%b want 1/1/0", gok, iok, tmo); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        data  = '0;
        pause = 1'b0;
        test_reset();
        test_single();
        test_all_req();
        test_rr_wrap();
        test_pause();
        test_reset_mid();
        test_late_req();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
